// File: rtl/card_grid_render.sv
`default_nettype none
// ============================================================================
// card_grid_render : per-card reveal/hide/match state plus a 2-stage pixel
//                    renderer for a ROWS x COLS grid of cards.  Rev 1.0
// ============================================================================
module card_grid_render #(
   parameter int COLS        = 4,
   parameter int ROWS        = 4,
   parameter int CARD_W      = 90,
   parameter int CARD_H      = 90,
   parameter int PITCH_X     = 100,
   parameter int PITCH_Y     = 100,
   parameter int ORG_X       = 130,
   parameter int ORG_Y       = 70,
   parameter int FLIP_FRAMES = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [9:0]                   HCount,
   input  logic [9:0]                   VCount,
   input  logic                         frame_tick,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [$clog2(ROWS*COLS)-1:0] cmd_idx,
   output logic [$clog2(CARD_H)-1:0]    rom_row,
   output logic [$clog2(CARD_W)-1:0]    rom_col,
   input  logic [2:0]                   rom_pix,
   output logic                         cardon,
   output logic [2:0]                   rgb,
   output logic                         all_matched
);
   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int RW    = $clog2(CARD_H);
   localparam int CW    = $clog2(CARD_W);
   localparam int CNT_W = $clog2(FLIP_FRAMES + 1);
   localparam int AW    = 16;

   localparam logic [1:0] C_ST_HIDDEN  = 2'b00;
   localparam logic [1:0] C_ST_FLIP    = 2'b01;
   localparam logic [1:0] C_ST_SHOWN   = 2'b10;
   localparam logic [1:0] C_ST_MATCHED = 2'b11;

   localparam logic [1:0] C_OP_REVEAL = 2'b00;
   localparam logic [1:0] C_OP_HIDE   = 2'b01;
   localparam logic [1:0] C_OP_MATCH  = 2'b10;
   localparam logic [1:0] C_OP_CLEAR  = 2'b11;

   logic [N-1:0][1:0]  state_q, state_d;
   logic               flip_busy_q, flip_busy_d;
   logic [IDX_W-1:0]   flip_idx_q, flip_idx_d;
   logic [CNT_W-1:0]   flip_cnt_q, flip_cnt_d;

   logic [RW-1:0]      rom_row_q, rom_row_d;
   logic [CW-1:0]      rom_col_q, rom_col_d;
   logic               hit1_q, hit1_d;
   logic [1:0]         cst1_q, cst1_d;
   logic               cardon_q, cardon_d;
   logic [2:0]         rgb_q, rgb_d;

   logic               w_accept;
   logic               w_idx_ok;
   logic [AW-1:0]      w_h, w_v, w_left, w_top;
   logic               w_hit_x, w_hit_y;
   logic [IDX_W-1:0]   w_col, w_row_base, w_idx;

   assign cmd_ready = ~flip_busy_q;
   assign w_accept  = cmd_valid & cmd_ready;

   // Out-of-range indices only exist when the card count is not a power of two.
   if ((1 << IDX_W) == N) begin : g_idx_full
      assign w_idx_ok = 1'b1;
   end else begin : g_idx_part
      assign w_idx_ok = (cmd_idx < IDX_W'(N));
   end

   always_comb begin
      state_d     = state_q;
      flip_busy_d = flip_busy_q;
      flip_idx_d  = flip_idx_q;
      flip_cnt_d  = flip_cnt_q;
      if (flip_busy_q && frame_tick) begin
         if (flip_cnt_q == CNT_W'(FLIP_FRAMES - 1)) begin
            state_d[flip_idx_q] = C_ST_SHOWN;
            flip_busy_d         = 1'b0;
            flip_cnt_d          = '0;
         end else begin
            flip_cnt_d = flip_cnt_q + 1'b1;
         end
      end
      // Applied after the tick so an accepted clear overrides a same-cycle tick.
      if (w_accept) begin
         if (cmd_op == C_OP_CLEAR) begin
            state_d     = '0;
            flip_busy_d = 1'b0;
            flip_cnt_d  = '0;
         end else if (w_idx_ok) begin
            case (cmd_op)
               C_OP_REVEAL: if (state_q[cmd_idx] == C_ST_HIDDEN) begin
                  state_d[cmd_idx] = C_ST_FLIP;
                  flip_busy_d      = 1'b1;
                  flip_idx_d       = cmd_idx;
                  flip_cnt_d       = '0;
               end
               C_OP_HIDE:  if (state_q[cmd_idx] == C_ST_SHOWN) state_d[cmd_idx] = C_ST_HIDDEN;
               C_OP_MATCH: if (state_q[cmd_idx] == C_ST_SHOWN) state_d[cmd_idx] = C_ST_MATCHED;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      all_matched = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (state_q[i] != C_ST_MATCHED) all_matched = 1'b0;
      end
   end

   assign w_h = AW'(HCount);
   assign w_v = AW'(VCount);

   // Stage 1: locate the card column/row under the current pixel.
   always_comb begin
      w_hit_x = 1'b0;
      w_left  = '0;
      w_col   = '0;
      for (int c = 0; c < COLS; c++) begin
         if (w_h >= AW'(ORG_X + c * PITCH_X) && w_h <= AW'(ORG_X + c * PITCH_X + CARD_W - 1)) begin
            w_hit_x = 1'b1;
            w_left  = AW'(ORG_X + c * PITCH_X);
            w_col   = IDX_W'(c);
         end
      end
      w_hit_y    = 1'b0;
      w_top      = '0;
      w_row_base = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (w_v >= AW'(ORG_Y + r * PITCH_Y) && w_v <= AW'(ORG_Y + r * PITCH_Y + CARD_H - 1)) begin
            w_hit_y    = 1'b1;
            w_top      = AW'(ORG_Y + r * PITCH_Y);
            w_row_base = IDX_W'(r * COLS);
         end
      end
   end

   assign w_idx = w_row_base + w_col;

   always_comb begin
      hit1_d    = w_hit_x & w_hit_y;
      cst1_d    = state_q[w_idx];
      rom_row_d = '0;
      rom_col_d = '0;
      if (w_hit_x && w_hit_y) begin
         rom_row_d = RW'(w_v - w_top);
         rom_col_d = CW'(w_h - w_left);
      end
   end

   // Stage 2: rom_pix belongs to the address currently presented on rom_row/rom_col.
   always_comb begin
      cardon_d = hit1_q;
      rgb_d    = 3'b000;
      if (hit1_q) begin
         case (cst1_q)
            C_ST_HIDDEN: rgb_d = 3'b100;
            C_ST_FLIP:   rgb_d = 3'b110;
            C_ST_SHOWN:  rgb_d = rom_pix;
            default:     rgb_d = {1'b0, rom_pix[1:0]};
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= '0;
         flip_busy_q <= 1'b0;
         flip_idx_q  <= '0;
         flip_cnt_q  <= '0;
         rom_row_q   <= '0;
         rom_col_q   <= '0;
         hit1_q      <= 1'b0;
         cst1_q      <= C_ST_HIDDEN;
         cardon_q    <= 1'b0;
         rgb_q       <= 3'b000;
      end else begin
         state_q     <= state_d;
         flip_busy_q <= flip_busy_d;
         flip_idx_q  <= flip_idx_d;
         flip_cnt_q  <= flip_cnt_d;
         rom_row_q   <= rom_row_d;
         rom_col_q   <= rom_col_d;
         hit1_q      <= hit1_d;
         cst1_q      <= cst1_d;
         cardon_q    <= cardon_d;
         rgb_q       <= rgb_d;
      end
   end

   assign rom_row = rom_row_q;
   assign rom_col = rom_col_q;
   assign cardon  = cardon_q;
   assign rgb     = rgb_q;

endmodule
`default_nettype wire
